// File: rtl/spike_bg_fetch_sched_if.sv
// Bundle between the fetch scheduler and its surroundings: line/pixel timing, obstacle table,
// the two ROM ports and the composited pixel stream.
interface spike_bg_fetch_sched_if #(parameter int N_OBS = 16);
  logic               frame_start;
  logic               line_start;
  logic [9:0]         next_y;
  logic               pixel_en;
  logic [9:0]         draw_x;
  logic [9:0]         draw_y;
  logic [8:0]         bg_scroll;
  logic [N_OBS-1:0]   obs_en;
  logic [10*N_OBS-1:0] obs_x_flat;
  logic [10*N_OBS-1:0] obs_y_flat;
  logic [9:0]         spike_addr;
  logic [2:0]         spike_q;
  logic [17:0]        bg_addr;
  logic [3:0]         bg_q;
  logic               pix_valid;
  logic               pix_layer;
  logic [3:0]         pix_index;
  logic               scan_busy;
  logic               overflow;
  logic               scan_err;

  modport master (
    output frame_start, line_start, next_y, pixel_en, draw_x, draw_y, bg_scroll,
           obs_en, obs_x_flat, obs_y_flat, spike_q, bg_q,
    input  spike_addr, bg_addr, pix_valid, pix_layer, pix_index, scan_busy, overflow, scan_err
  );
  modport slave (
    input  frame_start, line_start, next_y, pixel_en, draw_x, draw_y, bg_scroll,
           obs_en, obs_x_flat, obs_y_flat, spike_q, bg_q,
    output spike_addr, bg_addr, pix_valid, pix_layer, pix_index, scan_busy, overflow, scan_err
  );
endinterface

// File: rtl/spike_bg_fetch_sched.sv
// Spike/background fetch scheduler: per-line obstacle scan into a double-buffered active list,
// plus a 3-stage pixel pipeline issuing ROM addresses and compositing the returned indices.
module spike_bg_fetch_sched_cmp #(
  parameter int SPR_LOG2 = 5
) (
  input  logic                  en_i,
  input  logic [9:0]            draw_x_i,
  input  logic [9:0]            ex_i,
  input  logic [SPR_LOG2-1:0]   edy_i,
  output logic                  hit_o,
  output logic [2*SPR_LOG2-1:0] addr_o
);
  logic [10:0] dx;
  assign dx     = {1'b0, draw_x_i} - {1'b0, ex_i};
  assign hit_o  = en_i && ({1'b0, draw_x_i} >= {1'b0, ex_i}) &&
                  ({1'b0, draw_x_i} < ({1'b0, ex_i} + 11'(1 << SPR_LOG2)));
  assign addr_o = {edy_i, dx[SPR_LOG2-1:0]};
endmodule

module spike_bg_fetch_sched #(
  parameter int N_OBS      = 16,
  parameter int MAX_ACTIVE = 4,
  parameter int SPR_LOG2   = 5,
  parameter int BG_W       = 500,
  parameter int BG_H       = 500
) (
  input logic clock,
  input logic reset,
  spike_bg_fetch_sched_if.slave bus
);
  localparam int CW = $clog2(MAX_ACTIVE + 1);
  localparam int AW = $clog2(MAX_ACTIVE);
  localparam int IW = $clog2(N_OBS);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t              state_q;
  logic [IW-1:0]       idx_q;
  logic [9:0]          ny_q;
  logic [CW-1:0]       sh_cnt_q, lv_cnt_q;
  logic [9:0]          sh_x_q  [MAX_ACTIVE];
  logic [SPR_LOG2-1:0] sh_dy_q [MAX_ACTIVE];
  logic [9:0]          lv_x_q  [MAX_ACTIVE];
  logic [SPR_LOG2-1:0] lv_dy_q [MAX_ACTIVE];
  logic                overflow_q, scan_err_q;

  // Slot under examination this cycle
  logic [9:0]          slot_x, slot_y;
  logic                slot_hit;
  logic [SPR_LOG2-1:0] slot_dy;
  assign slot_x   = bus.obs_x_flat[10*idx_q +: 10];
  assign slot_y   = bus.obs_y_flat[10*idx_q +: 10];
  assign slot_hit = bus.obs_en[idx_q] && ({1'b0, ny_q} >= {1'b0, slot_y}) &&
                    ({1'b0, ny_q} < ({1'b0, slot_y} + 11'(1 << SPR_LOG2)));
  assign slot_dy  = SPR_LOG2'(ny_q - slot_y);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ny_q       <= '0;
      sh_cnt_q   <= '0;
      lv_cnt_q   <= '0;
      overflow_q <= 1'b0;
      scan_err_q <= 1'b0;
      for (int j = 0; j < MAX_ACTIVE; j++) begin
        sh_x_q[j] <= '0; sh_dy_q[j] <= '0; lv_x_q[j] <= '0; lv_dy_q[j] <= '0;
      end
    end else begin
      if (state_q == SCAN) begin
        if (slot_hit) begin
          if (sh_cnt_q < CW'(MAX_ACTIVE)) begin
            sh_x_q[sh_cnt_q[AW-1:0]]  <= slot_x;
            sh_dy_q[sh_cnt_q[AW-1:0]] <= slot_dy;
            sh_cnt_q                  <= sh_cnt_q + 1'b1;
          end else begin
            overflow_q <= 1'b1;
          end
        end
        idx_q <= idx_q + 1'b1;
        if (idx_q == IW'(N_OBS - 1)) state_q <= IDLE;
      end
      // frame_start is applied before a coincident line_start: later assignments win
      if (bus.frame_start) begin
        sh_cnt_q   <= '0;
        lv_cnt_q   <= '0;
        overflow_q <= 1'b0;
        scan_err_q <= 1'b0;
        state_q    <= IDLE;
      end
      if (bus.line_start) begin
        lv_x_q   <= sh_x_q;
        lv_dy_q  <= sh_dy_q;
        lv_cnt_q <= bus.frame_start ? '0 : sh_cnt_q;
        sh_cnt_q <= '0;
        ny_q     <= bus.next_y;
        idx_q    <= '0;
        state_q  <= SCAN;
        if (state_q == SCAN && !bus.frame_start) scan_err_q <= 1'b1;
      end
    end
  end

  // Spike match against the live list; lowest index wins
  logic [MAX_ACTIVE-1:0]                     e_hit;
  logic [MAX_ACTIVE-1:0][2*SPR_LOG2-1:0]     e_addr;
  for (genvar j = 0; j < MAX_ACTIVE; j++) begin : g_ent
    spike_bg_fetch_sched_cmp #(.SPR_LOG2(SPR_LOG2)) u_cmp (
      .en_i    (CW'(j) < lv_cnt_q),
      .draw_x_i(bus.draw_x),
      .ex_i    (lv_x_q[j]),
      .edy_i   (lv_dy_q[j]),
      .hit_o   (e_hit[j]),
      .addr_o  (e_addr[j])
    );
  end

  logic                  m_hit;
  logic [2*SPR_LOG2-1:0] m_addr;
  always_comb begin
    m_hit  = 1'b0;
    m_addr = '0;
    for (int j = MAX_ACTIVE - 1; j >= 0; j--) begin
      if (e_hit[j]) begin
        m_hit  = 1'b1;
        m_addr = e_addr[j];
      end
    end
  end

  // Scroll never exceeds BG_W-1, so one conditional subtract folds the wrap
  logic [10:0] bsum, bx;
  logic [17:0] bg_lin;
  logic        bg_in;
  assign bsum   = 11'(bus.draw_x) + 11'(bus.bg_scroll);
  assign bx     = (bsum >= 11'(BG_W)) ? bsum - 11'(BG_W) : bsum;
  assign bg_lin = 18'(bus.draw_y) * 18'(BG_W) + 18'(bx);
  assign bg_in  = (bus.draw_y < 10'(BG_H)) && (bus.draw_x < 10'(BG_W));

  logic [2*SPR_LOG2-1:0] spike_addr_q;
  logic [17:0]           bg_addr_q;
  logic [1:0]            vld_pipe_q, hit_pipe_q;
  logic                  pix_valid_q, pix_layer_q;
  logic [3:0]            pix_index_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      spike_addr_q <= '0;
      bg_addr_q    <= '0;
      vld_pipe_q   <= '0;
      hit_pipe_q   <= '0;
      pix_valid_q  <= 1'b0;
      pix_layer_q  <= 1'b0;
      pix_index_q  <= '0;
    end else begin
      if (bus.pixel_en) begin
        spike_addr_q <= m_hit ? m_addr : '0;
        bg_addr_q    <= bg_in ? bg_lin : '0;
      end
      vld_pipe_q  <= {vld_pipe_q[0], bus.pixel_en};
      hit_pipe_q  <= {hit_pipe_q[0], bus.pixel_en & m_hit};
      pix_valid_q <= vld_pipe_q[1];
      // Spike index 0 is transparent and lets the background through
      if (hit_pipe_q[1] && bus.spike_q != 3'd0) begin
        pix_layer_q <= 1'b1;
        pix_index_q <= {1'b0, bus.spike_q};
      end else begin
        pix_layer_q <= 1'b0;
        pix_index_q <= bus.bg_q;
      end
    end
  end

  assign bus.spike_addr = spike_addr_q;
  assign bus.bg_addr    = bg_addr_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_layer  = pix_layer_q;
  assign bus.pix_index  = pix_index_q;
  assign bus.scan_busy  = (state_q == SCAN);
  assign bus.overflow   = overflow_q;
  assign bus.scan_err   = scan_err_q;
endmodule

// File: tb/tb_spike_bg_fetch_sched.sv
// Directed bench for spike_bg_fetch_sched: scan timing, list swap, overflow, scan restart,
// ROM address generation and compositing, each with hand-computed expectations.
module tb_spike_bg_fetch_sched;
  logic clock = 1'b0;
  logic reset;
  int   errs = 0;
  int   checks = 0;

  spike_bg_fetch_sched_if #(.N_OBS(16)) bus();
  spike_bg_fetch_sched dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic set_slot(input int i, input logic en, input logic [9:0] x, input logic [9:0] y);
    bus.obs_en[i] = en;
    bus.obs_x_flat[10*i +: 10] = x;
    bus.obs_y_flat[10*i +: 10] = y;
  endtask

  task automatic line_pulse(input logic [9:0] y);
    bus.next_y = y; bus.line_start = 1'b1; tick(); bus.line_start = 1'b0;
  endtask

  task automatic frame_pulse();
    bus.frame_start = 1'b1; tick(); bus.frame_start = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.scan_busy && n < 40) begin n++; tick(); end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.scan_busy && n < 40) begin n++; tick(); end
    chk("idle_timeout", {31'd0, bus.scan_busy}, 0);
  endtask

  task automatic run_pix(input string tag, input int x, input int y, input int sq, input int bq,
                         input int esa, input int eba, input int elay, input int eidx);
    bus.draw_x = 10'(x); bus.draw_y = 10'(y);
    bus.spike_q = 3'(sq); bus.bg_q = 4'(bq);
    bus.pixel_en = 1'b1; tick(); bus.pixel_en = 1'b0;
    chk({tag, "_spike_addr"}, 32'(bus.spike_addr), 32'(esa));
    chk({tag, "_bg_addr"}, 32'(bus.bg_addr), 32'(eba));
    tick();
    chk({tag, "_valid_t2"}, {31'd0, bus.pix_valid}, 0);
    chk({tag, "_addr_hold"}, 32'(bus.spike_addr), 32'(esa));
    tick();
    chk({tag, "_valid_t3"}, {31'd0, bus.pix_valid}, 1);
    chk({tag, "_layer"}, {31'd0, bus.pix_layer}, 32'(elay));
    chk({tag, "_index"}, 32'(bus.pix_index), 32'(eidx));
    tick();
    chk({tag, "_valid_t4"}, {31'd0, bus.pix_valid}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1);
  end

  initial begin
    int n;
    reset = 1'b1;
    bus.frame_start = 0; bus.line_start = 0; bus.next_y = 0; bus.pixel_en = 0;
    bus.draw_x = 0; bus.draw_y = 0; bus.bg_scroll = 0;
    bus.obs_en = '0; bus.obs_x_flat = '0; bus.obs_y_flat = '0;
    bus.spike_q = 0; bus.bg_q = 0;
    tick(); tick();
    chk("rst_spike_addr", 32'(bus.spike_addr), 0);
    chk("rst_bg_addr", 32'(bus.bg_addr), 0);
    chk("rst_pix_valid", {31'd0, bus.pix_valid}, 0);
    chk("rst_scan_busy", {31'd0, bus.scan_busy}, 0);
    chk("rst_overflow", {31'd0, bus.overflow}, 0);
    chk("rst_scan_err", {31'd0, bus.scan_err}, 0);
    reset = 1'b0;
    tick();

    // Single obstacle: scan length, then swap in {x=100, dy=10}
    set_slot(0, 1'b1, 10'd100, 10'd0);
    line_pulse(10'd10);
    count_busy(n);
    chk("scan_len", 32'(n), 16);
    line_pulse(10'd11);
    run_pix("spk", 105, 10, 3, 5, 325, 5105, 1, 3);
    run_pix("transp", 105, 10, 0, 9, 325, 5105, 0, 9);
    run_pix("miss132", 132, 10, 3, 9, 0, 5132, 0, 9);
    bus.bg_scroll = 9'd499;
    run_pix("bgwrap", 2, 1, 0, 7, 0, 501, 0, 7);
    run_pix("bgoff", 600, 1, 0, 7, 0, 0, 0, 7);
    bus.bg_scroll = 9'd10;
    run_pix("bgnowrap", 5, 499, 0, 4, 0, 249515, 0, 4);
    bus.bg_scroll = 9'd0;
    wait_idle();

    // Six hits on line 40: slots 0-3 kept, overflow sticky
    frame_pulse();
    set_slot(0, 1'b1, 10'd50, 10'd30);
    set_slot(1, 1'b1, 10'd40, 10'd35);
    set_slot(2, 1'b1, 10'd300, 10'd20);
    set_slot(3, 1'b1, 10'd350, 10'd20);
    set_slot(4, 1'b1, 10'd400, 10'd20);
    set_slot(5, 1'b1, 10'd450, 10'd25);
    line_pulse(10'd40);
    wait_idle();
    chk("ovf_set", {31'd0, bus.overflow}, 1);
    chk("ovf_no_err", {31'd0, bus.scan_err}, 0);
    line_pulse(10'd40);
    run_pix("ovl_win", 55, 40, 2, 1, 325, 20055, 1, 2);
    run_pix("keep3", 355, 40, 1, 1, 645, 20355, 1, 1);
    run_pix("drop4", 405, 40, 1, 6, 0, 20405, 0, 6);
    wait_idle();
    chk("ovf_sticky", {31'd0, bus.overflow}, 1);
    frame_pulse();
    chk("ovf_clr", {31'd0, bus.overflow}, 0);
    run_pix("fs_empty", 55, 40, 2, 6, 0, 20055, 0, 6);

    // Restart 5 cycles into a scan: partial list (slots 0,1) goes live
    for (int i = 2; i < 6; i++) set_slot(i, 1'b0, 10'd0, 10'd0);
    set_slot(10, 1'b1, 10'd200, 10'd40);
    line_pulse(10'd40);
    for (int i = 0; i < 4; i++) tick();
    line_pulse(10'd40);
    chk("scan_err_set", {31'd0, bus.scan_err}, 1);
    count_busy(n);
    chk("restart_len", 32'(n), 16);
    run_pix("part0", 55, 40, 1, 6, 325, 20055, 1, 1);
    run_pix("part1", 45, 40, 1, 6, 165, 20045, 1, 1);
    run_pix("part10", 205, 40, 1, 6, 0, 20205, 0, 6);
    frame_pulse();
    chk("scan_err_clr", {31'd0, bus.scan_err}, 0);

    // Coincident frame_start + line_start while live list is populated
    line_pulse(10'd40);
    wait_idle();
    bus.next_y = 10'd40; bus.frame_start = 1'b1; bus.line_start = 1'b1;
    tick();
    bus.frame_start = 1'b0; bus.line_start = 1'b0;
    chk("coinc_busy", {31'd0, bus.scan_busy}, 1);
    chk("coinc_no_err", {31'd0, bus.scan_err}, 0);
    run_pix("coinc_empty", 55, 40, 1, 6, 0, 20055, 0, 6);
    wait_idle();

    // Reset with a pixel in flight: nothing emerges
    bus.draw_x = 10'd55; bus.draw_y = 10'd40; bus.pixel_en = 1'b1;
    tick();
    bus.pixel_en = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rstmid_addr", 32'(bus.bg_addr), 0);
    chk("rstmid_v1", {31'd0, bus.pix_valid}, 0);
    tick();
    chk("rstmid_v2", {31'd0, bus.pix_valid}, 0);
    tick();
    chk("rstmid_v3", {31'd0, bus.pix_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/spike_bg_fetch_sched.md
Name: spike_bg_fetch_sched

Overview:
- Per-pixel fetch scheduler for the 32x32 spike sprite ROM (3-bit index) and the 500x500 background ROM (4-bit index).
- During each line it scans the obstacle table to build a short active list for a later line. During active video it issues ROM addresses and absorbs the ROMs' 1-cycle registered read latency.
- It emits a composited, pipeline-aligned palette index to the VGA colour mapper.

Parameters:
- N_OBS, 16, number of obstacle slots in the table
- MAX_ACTIVE, 4, maximum obstacles resolvable on one scanline
- SPR_LOG2, 5, log2 of spike sprite edge (32 px); spike ROM depth = 2^(2*SPR_LOG2)
- BG_W, 500, background width in pixels
- BG_H, 500, background height in pixels

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse per frame; clears lists and error flags
- line_start  in  1  one-cycle pulse per line, before that line's active pixels
- next_y  in  10  line number whose list is built by the scan this pulse starts
- pixel_en  in  1  active-video pixel strobe
- draw_x  in  10  current pixel x; sampled with pixel_en
- draw_y  in  10  current pixel y; sampled with pixel_en
- bg_scroll  in  9  background horizontal scroll, 0..BG_W-1
- obs_en  in  N_OBS  per-slot valid
- obs_x_flat  in  10*N_OBS  slot i x at bits [10i+9:10i]
- obs_y_flat  in  10*N_OBS  slot i y, same packing
- spike_addr  out  10  spike ROM address (registered)
- spike_q  in  3  spike ROM data, 1 cycle after spike_addr
- bg_addr  out  18  background ROM address (registered)
- bg_q  in  4  background ROM data, 1 cycle after bg_addr
- pix_valid  out  1  composited pixel valid
- pix_layer  out  1  0 = background, 1 = spike
- pix_index  out  4  palette index
- scan_busy  out  1  scanner FSM not IDLE
- overflow  out  1  sticky: more than MAX_ACTIVE hits on a line
- scan_err  out  1  sticky: line_start arrived while scanning

Behaviour:
- Reset: all outputs 0, FSM IDLE, live and shadow list counts 0, pipeline valids 0.
- Lists are double-buffered. Each entry holds x[9:0] and dy[SPR_LOG2-1:0]. The live list drives pixels; the scanner fills the shadow list.
- line_start: live <= shadow (entries and count), shadow count <= 0, capture next_y, idx <= 0, FSM -> SCAN.
- FSM states IDLE and SCAN:
  - SCAN examines one slot per cycle, idx 0..N_OBS-1.
  - Slot i hits if obs_en[i], next_y >= y_i, and next_y < y_i + 2^SPR_LOG2. Compare at 11 bits, no wrap.
  - On a hit with count < MAX_ACTIVE: append {x_i, next_y - y_i}.
  - On a hit with count == MAX_ACTIVE: drop the slot and set overflow.
  - After idx = N_OBS-1, FSM -> IDLE. A scan takes exactly N_OBS cycles.
- line_start while in SCAN: set scan_err, swap the partial shadow list, restart the scan.
- frame_start: both counts 0, overflow 0, scan_err 0, FSM IDLE. If frame_start and line_start coincide, frame_start is applied first, then line_start (swap of empty list, scan starts).
- Pixel pipeline, pixel_en at edge t:
  - Edge t+1: bg_addr and spike_addr register; hit flag and hit-valid enter stage 1.
  - Edge t+2: ROMs register q.
  - Edge t+3: pix_* register.
  - Latency is exactly 3 cycles. Throughput is 1 pixel/cycle with no bubbles.
- Spike match: live entry j matches if draw_x >= x_j and draw_x < x_j + 32 (11-bit compare). The lowest j among the first count entries wins. spike_addr = {dy_j, (draw_x - x_j)[4:0]}. With no match, spike_addr = 0.
- Background address:
  - bx = draw_x + bg_scroll; subtract BG_W if the result is >= BG_W.
  - bg_addr = draw_y*BG_W + bx when draw_y < BG_H and draw_x < BG_W; otherwise bg_addr = 0.
- Compose:
  - If the delayed hit is set and spike_q != 0 (index 0 is transparent): pix_layer = 1, pix_index = {1'b0, spike_q}.
  - Otherwise: pix_layer = 0, pix_index = bg_q.
- When pixel_en = 0: address registers hold their values, and pix_valid = 0 three cycles later.
- Swapping lists while pixels are in flight does not affect pixels already past stage 1.
- Reset mid-line: the pipeline flushes, and no pix_valid is emitted from pre-reset pixels.

Test Plan:
- Reset, then line_start with next_y=10, slot0 {en, x=100, y=0} -> scan_busy high for 16 cycles; next line_start swaps in entry {x=100, dy=10}.
- Live {x=100, dy=10}, pixel_en at draw_x=105, draw_y=10 -> spike_addr = 10*32+5 = 325 at t+1. With spike_q=3: pix_valid, layer=1, index=3 at t+3.
- Same setup, spike_q=0, bg_q=9 -> layer=0, index=9. Draw_x=132 (outside 100..131) -> spike_addr=0, layer=0.
- bg_scroll=499, draw_x=2, draw_y=1 -> bg_addr = 500+1 = 501. Draw_x=600 -> bg_addr=0.
- Six enabled slots all covering next_y=40 with MAX_ACTIVE=4 -> count=4 (slots 0-3 kept), overflow=1 until frame_start. Overlapping entries at x=50 and x=40, pixel x=55 -> the lower-indexed entry wins.
- line_start asserted again 5 cycles into a scan -> scan_err=1, partial list swapped, scan restarts from idx 0.
